// File: rtl/writeback_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | writeback_arbiter: RS/LSB result queues, round-robin onto one ROB port.  |
// | Optional WB_ARB_BYPASS_EN lets an empty-queue source skip its queue.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module writeback_arbiter #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             predict_fail,
   input  logic             rs_valid,
   input  logic [TAG_W-1:0] rs_tag,
   input  logic [31:0]      rs_val,
   input  logic             lsb_valid,
   input  logic [TAG_W-1:0] lsb_tag,
   input  logic [31:0]      lsb_val,
   output logic             rs_full,
   output logic             lsb_full,
   output logic             submit_valid,
   output logic [TAG_W-1:0] submit_tag,
   output logic [31:0]      submit_val,
   output logic             overflow_err
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   // Source index 0 is the RS, 1 is the LSB throughout.
   logic [1:0]       in_valid;
   logic [TAG_W-1:0] in_tag [2];
   logic [31:0]      in_val [2];

   logic [TAG_W-1:0] tag_mem [2][DEPTH];
   logic [31:0]      val_mem [2][DEPTH];
   logic [PTR_W-1:0] head [2];
   logic [PTR_W-1:0] tail [2];
   logic [CNT_W-1:0] cnt  [2];
   logic             rr_last;

   logic [1:0]       full;
   logic [1:0]       has;
   logic [1:0]       live;
   logic [1:0]       byp;
   logic [1:0]       elig;
   logic [1:0]       grant;
   logic [1:0]       push;
   logic [1:0]       pop;
   logic             act;
   logic             drop;
   logic             sel;
   logic [TAG_W-1:0] sel_tag;
   logic [31:0]      sel_val;

   assign in_valid  = {lsb_valid, rs_valid};
   assign in_tag[0] = rs_tag;
   assign in_tag[1] = lsb_tag;
   assign in_val[0] = rs_val;
   assign in_val[1] = lsb_val;
   assign act       = rdy_in & ~predict_fail;
   assign rs_full   = full[0];
   assign lsb_full  = full[1];

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      full = '0;
      has  = '0;
      live = '0;
      for (int s = 0; s < 2; s++) begin
         full[s] = (cnt[s] == FULL_CNT);
         has[s]  = (cnt[s] != '0);
         live[s] = in_valid[s] && (in_tag[s] != '0);
      end
   end

   always_comb begin
`ifdef WB_ARB_BYPASS_EN
      byp = ~has & live;
`else
      byp = '0;
`endif
      elig  = has | byp;
      grant = '0;
      if (act) begin
         if (elig == 2'b11) grant = rr_last ? 2'b01 : 2'b10;
         else               grant = elig;
      end
      pop  = grant & has;
      // A granted source with an empty queue is being bypassed, so it is not enqueued.
      push = act ? (live & ~full & ~(grant & ~has)) : 2'b00;
      drop = act & (|(live & full));
      sel  = grant[1];
      sel_tag = byp[sel] ? in_tag[sel] : tag_mem[sel][head[sel]];
      sel_val = byp[sel] ? in_val[sel] : val_mem[sel][head[sel]];
   end

   always_ff @(posedge clk_in) begin
      for (int s = 0; s < 2; s++) begin
         if (!rst_in && push[s]) begin
            tag_mem[s][tail[s]] <= in_tag[s];
            val_mem[s][tail[s]] <= in_val[s];
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int s = 0; s < 2; s++) begin
            head[s] <= '0;
            tail[s] <= '0;
            cnt[s]  <= '0;
         end
         rr_last      <= 1'b1;
         overflow_err <= 1'b0;
         submit_valid <= 1'b0;
         submit_tag   <= '0;
         submit_val   <= '0;
      end else if (rdy_in) begin
         if (predict_fail) begin
            for (int s = 0; s < 2; s++) begin
               head[s] <= '0;
               tail[s] <= '0;
               cnt[s]  <= '0;
            end
            rr_last      <= 1'b1;
            submit_valid <= 1'b0;
         end else begin
            for (int s = 0; s < 2; s++) begin
               if (push[s]) tail[s] <= next_ptr(tail[s]);
               if (pop[s])  head[s] <= next_ptr(head[s]);
               cnt[s] <= cnt[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
            end
            if (drop) overflow_err <= 1'b1;
            submit_valid <= |grant;
            if (|grant) begin
               submit_tag <= sel_tag;
               submit_val <= sel_val;
               rr_last    <= grant[1];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// tb_writeback_arbiter: directed stimulus with a scoreboard queue checked by a
// separate monitor whenever the arbiter presents a fresh submit.
module tb_writeback_arbiter;
   localparam int TAG_W = 4;
   localparam int FULL_RS  [8] = '{1, 2, 3, 4, 6, 7, 11, 5};
   localparam int FULL_LSB [4] = '{8, 9, 10, 12};

   logic             clk = 1'b0;
   logic             rst_in;
   logic             rdy_in;
   logic             predict_fail;
   logic             rs_valid;
   logic [TAG_W-1:0] rs_tag;
   logic [31:0]      rs_val;
   logic             lsb_valid;
   logic [TAG_W-1:0] lsb_tag;
   logic [31:0]      lsb_val;
   logic             rs_full;
   logic             lsb_full;
   logic             submit_valid;
   logic [TAG_W-1:0] submit_tag;
   logic [31:0]      submit_val;
   logic             overflow_err;

   always #5 clk = ~clk;

   writeback_arbiter #(.DEPTH(4), .TAG_W(TAG_W)) dut (
      .clk_in       (clk),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .predict_fail (predict_fail),
      .rs_valid     (rs_valid),
      .rs_tag       (rs_tag),
      .rs_val       (rs_val),
      .lsb_valid    (lsb_valid),
      .lsb_tag      (lsb_tag),
      .lsb_val      (lsb_val),
      .rs_full      (rs_full),
      .lsb_full     (lsb_full),
      .submit_valid (submit_valid),
      .submit_tag   (submit_tag),
      .submit_val   (submit_val),
      .overflow_err (overflow_err)
   );

   logic [35:0] exp_q [$];
   int checks = 0;
   int passed = 0;

   function automatic logic [31:0] rv(input int t);
      return 32'hA500_0000 | 32'(t);
   endfunction

   function automatic logic [31:0] lv(input int t);
      return 32'h5A00_0000 | 32'(t);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rdy_in = 1'b1; predict_fail = 1'b0;
      rs_valid = 1'b0; rs_tag = '0; rs_val = '0;
      lsb_valid = 1'b0; lsb_tag = '0; lsb_val = '0;
   endtask

   task automatic drive(input logic rv_en, input int rt, input logic lv_en, input int lt);
      rs_valid  = rv_en; rs_tag  = TAG_W'(rt); rs_val  = rv(rt);
      lsb_valid = lv_en; lsb_tag = TAG_W'(lt); lsb_val = lv(lt);
   endtask

   task automatic exp_rs(input int t);
      exp_q.push_back({TAG_W'(t), rv(t)});
   endtask

   task automatic exp_lsb(input int t);
      exp_q.push_back({TAG_W'(t), lv(t)});
   endtask

   task automatic do_reset();
      idle();
      rst_in = 1'b1;
      step();
      step();
      rst_in = 1'b0;
   endtask

   task automatic drain(input string name);
      idle();
      repeat (8) step();
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Monitor: only a submit produced by an enabled, non-reset edge is a new result.
   initial begin
      logic en;
      forever begin
         @(posedge clk);
         en = rdy_in && !rst_in;
         @(negedge clk);
         if (en && submit_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_submit: got tag %0d val %0h, expected no submit",
                        submit_tag, submit_val);
            end else begin
               check("sb_result", {submit_tag, submit_val}, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      do_reset();
      check("rst_submit_valid", submit_valid, 0);
      check("rst_submit_tag", submit_tag, 0);
      check("rst_submit_val", submit_val, 0);
      check("rst_rs_full", rs_full, 0);
      check("rst_lsb_full", lsb_full, 0);
      check("rst_overflow", overflow_err, 0);

      // Single result: two-cycle latency, one cycle wide.
      exp_q.push_back({4'd3, 32'h11});
      rs_valid = 1'b1; rs_tag = 4'd3; rs_val = 32'h11;
      step();
      idle();
      check("single_not_yet", submit_valid, 0);
      step();
      check("single_out", {submit_valid, submit_tag}, {1'b1, 4'd3});
      step();
      check("single_once", submit_valid, 0);
      drain("single_drain");

      // Contention: RS first after reset, then strict alternation.
      do_reset();
      exp_rs(1); exp_lsb(4); exp_rs(2); exp_lsb(5); exp_rs(3); exp_lsb(6);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, k + 1, 1'b1, k + 4);
         step();
         if (k > 0) check("contend_busy", submit_valid, 1);
      end
      idle();
      for (int k = 0; k < 4; k++) begin
         step();
         check("contend_busy", submit_valid, 1);
      end
      step();
      check("contend_gap", submit_valid, 0);
      drain("contend_drain");

      // Full: RS fed every cycle, LSB every other cycle; 8th RS push (tag 5) hits a full queue.
      do_reset();
      exp_rs(1); exp_lsb(8); exp_rs(2); exp_lsb(9); exp_rs(3); exp_lsb(10);
      exp_rs(4); exp_lsb(12); exp_rs(6); exp_rs(7); exp_rs(11);
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, FULL_RS[k], (k % 2) == 0, ((k % 2) == 0) ? FULL_LSB[k / 2] : 0);
         step();
         if (k == 6) begin
            check("full_rs_full", rs_full, 1);
            check("full_lsb_not_full", lsb_full, 0);
            check("full_no_overflow_yet", overflow_err, 0);
         end
      end
      idle();
      check("full_overflow", overflow_err, 1);
      check("full_rs_after_pop", rs_full, 0);
      drain("full_drain");
      check("full_overflow_sticky", overflow_err, 1);

      // Flush with RS holding tags 1,2 and LSB tag 7 arriving in the flush cycle.
      do_reset();
      exp_rs(8); exp_lsb(6); exp_rs(9);
      drive(1'b1, 8, 1'b0, 0); step();
      drive(1'b1, 1, 1'b1, 6); step();
      drive(1'b1, 2, 1'b0, 0); step();
      drive(1'b0, 0, 1'b1, 7); predict_fail = 1'b1; step();
      predict_fail = 1'b0;
      check("flush_submit_low", submit_valid, 0);
      drive(1'b1, 9, 1'b0, 0); step();
      idle(); step();
      check("flush_next_tag", {submit_valid, submit_tag}, {1'b1, 4'd9});
      drain("flush_drain");

      // Pause: outputs hold tag 3 while tag 4 waits; inputs during pause are lost.
      do_reset();
      exp_lsb(3); exp_rs(4);
      drive(1'b0, 0, 1'b1, 3); step();
      drive(1'b1, 4, 1'b0, 0); step();
      check("pause_before", {submit_valid, submit_tag}, {1'b1, 4'd3});
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 5, 1'b1, 6);
         rdy_in = 1'b0;
         predict_fail = 1'b1;
         step();
         check("pause_frozen", {submit_valid, submit_tag}, {1'b1, 4'd3});
      end
      idle(); step();
      check("pause_resume", {submit_valid, submit_tag}, {1'b1, 4'd4});
      drain("pause_drain");

      // Wrap: ten back-to-back RS results, then a tag-0 valid that must be ignored.
      do_reset();
      for (int t = 1; t <= 10; t++) begin
         exp_rs(t);
         drive(1'b1, t, 1'b0, 0);
         step();
      end
      drive(1'b1, 0, 1'b1, 0); step();
      drain("wrap_drain");
      check("wrap_no_overflow", overflow_err, 0);

      // Reset mid-stream discards queued RS tag 2 and LSB tag 3.
      do_reset();
      exp_rs(1);
      drive(1'b1, 1, 1'b1, 3); step();
      drive(1'b1, 2, 1'b0, 0); step();
      check("midrst_before", {submit_valid, submit_tag}, {1'b1, 4'd1});
      drive(1'b1, 4, 1'b0, 0);
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      check("midrst_cleared", {submit_valid, submit_tag}, {1'b0, 4'd0});
      drain("midrst_drain");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
